result_uart_tx: RTL and testbench

- UART 8N1 transmitter that serializes p_N-bit result words (e.g. salidas_final) out of the system top on uart_txd.
- It is the transmit end of the system UART link: it takes words from the datapath side through a valid/ready handshake and drives the line to the host.
- It sends each word as p_N/8 bytes, least-significant byte first.

---
 rtl/result_uart_tx.sv | 137 +++++++++++++
 tb/tb_result_uart_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx.sv
// UART 8N1 transmitter: accepts a p_N-bit word over valid/ready and sends it
// as p_N/8 bytes, least-significant byte first, on uart_txd.
module result_uart_tx #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 57600,
  parameter int p_N            = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [p_N-1:0] i_data,
  input  logic           i_valid,
  output logic           o_ready,
  output logic           o_done,
  output logic           uart_txd
);

  localparam int BAUD_DIV = clk_freq / uart_baud_rate;
  localparam int NBYTES   = p_N / 8;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [BW-1:0]  byte_q, byte_d;
  logic [p_N-1:0] shreg_q, shreg_d;
  logic           txd_q, txd_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;

  logic accept;
  logic baud_tick;

  assign accept    = i_valid && ready_q;
  assign baud_tick = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // The word is shifted right one bit per data bit, so bit 0 is always the
  // bit on the line and the next byte lines up automatically after eight shifts.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        byte_d = '0;
        if (accept) begin
          shreg_d = i_data;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          if (byte_q != BYTE_LAST) begin
            byte_d  = byte_q + BW'(1);
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the FSM
  // by one cycle; done fires on the first IDLE cycle after a word.
  always_comb begin
    txd_d   = 1'b1;
    ready_d = (state_q == IDLE) && !accept;
    done_d  = (state_q == IDLE) && !ready_q;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign uart_txd = txd_q;
  assign o_ready  = ready_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Randomized self-checking bench for result_uart_tx; the expected line is
// built from the 8N1 frame definition and compared cycle by cycle.
module tb_result_uart_tx;

  localparam int B  = 8;
  localparam int NB = 2;
  localparam int W  = NB * 10 * B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready, o_done, uart_txd;

  logic [15:0] d_data = '0;
  logic        d_valid = 1'b0;
  logic        d_ready, d_done, d_txd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  result_uart_tx #(.clk_freq(8), .uart_baud_rate(1), .p_N(16)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_done(o_done), .uart_txd(uart_txd)
  );

  result_uart_tx #(.clk_freq(50000000), .uart_baud_rate(57600), .p_N(16)) dut_def (
    .clk(clk), .rst(rst), .i_data(d_data), .i_valid(d_valid),
    .o_ready(d_ready), .o_done(d_done), .uart_txd(d_txd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Symbol sym of a word's serial stream: each byte is start(0), 8 data bits LSB first, stop(1).
  function automatic logic frame_bit(input logic [15:0] w, input int sym);
    int b;
    int p;
    b = sym / 10;
    p = sym % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[b*8 + p - 1];
  endfunction

  // Called just after a clock edge. Sends w, checks every line cycle, the
  // decoded bytes and the done/ready pulse at acceptance + W + 1.
  task automatic send_word(input logic [15:0] w, input bit keep_valid, input logic [15:0] next_w,
                           input bit inject, input bit check_gap);
    int waits = 0;
    int errs = 0;
    int ctrl_errs = 0;
    int inj_at = -1;
    int acc;
    int sym;
    logic [15:0] dec = '0;
    i_data  = w;
    i_valid = 1'b1;
    while (!o_ready && waits < 400) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!o_ready) begin
      check_eq("ready_wait", 32'(o_ready), 32'd1);
      i_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    if (check_gap) check_eq("b2b_accept_after_done", 32'(acc - last_done), 32'd1);
    if (keep_valid) begin
      i_data = next_w;
    end else begin
      i_valid = 1'b0;
      i_data  = 16'($urandom);
    end
    if (inject && !keep_valid) inj_at = $urandom_range(10, W - 12);
    for (int i = 1; i <= W + 1; i++) begin
      @(posedge clk); #1;
      if (i == inj_at) begin
        i_valid = 1'b1;
        i_data  = 16'hFFFF;
      end
      if (i == inj_at + 3) i_valid = 1'b0;
      if (i <= W) begin
        sym = (i - 1) / B;
        if (uart_txd !== frame_bit(w, sym)) errs++;
        if (o_ready !== 1'b0 || o_done !== 1'b0) ctrl_errs++;
        if ((i - 1) % B == B / 2 && sym % 10 >= 1 && sym % 10 <= 8)
          dec[(sym / 10) * 8 + sym % 10 - 1] = uart_txd;
      end
    end
    check_eq("line_cycles", 32'(errs), 32'd0);
    check_eq("busy_ready_done", 32'(ctrl_errs), 32'd0);
    check_eq("decoded_word", 32'(dec), 32'(w));
    check_eq("done_pulse", 32'(o_done), 32'd1);
    check_eq("ready_after", 32'(o_ready), 32'd1);
    check_eq("done_latency", 32'(cyc - acc), 32'(W + 1));
    last_done = cyc;
    $display("word %04h: accepted at cycle %0d, done at cycle %0d, %0d line errors", w, acc, cyc, errs);
  endtask

  initial begin
    int lows;
    int acc;
    int first_low;
    int first_high;
    int done_at;
    logic [15:0] w;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_txd", 32'(uart_txd), 32'd1);
    check_eq("rst_ready", 32'(o_ready), 32'd1);
    check_eq("rst_done", 32'(o_done), 32'd0);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (uart_txd !== 1'b1 || o_done !== 1'b0) lows++;
    end
    check_eq("idle_line", 32'(lows), 32'd0);
    $display("reset/idle: %0d bad idle cycles", lows);

    send_word(16'hA53C, 1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("done_one_cycle", 32'(o_done), 32'd0);

    // Ignored request during a word: no third byte may follow.
    send_word(16'h0001, 1'b0, 16'h0, 1'b1, 1'b0);
    lows = 0;
    for (int i = 0; i < 3 * B; i++) begin
      @(posedge clk); #1;
      if (uart_txd !== 1'b1) lows++;
    end
    check_eq("no_extra_byte", 32'(lows), 32'd0);

    // Back-to-back
    send_word(16'h1234, 1'b1, 16'h5678, 1'b0, 1'b0);
    send_word(16'h5678, 1'b0, 16'h0, 1'b0, 1'b1);

    // Randomized words, gaps, ignored requests and back-to-back pairs
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        send_word(w, 1'b1, ~w, 1'b0, 1'b0);
        send_word(~w, 1'b0, 16'h0, 1'b0, 1'b1);
      end else begin
        send_word(w, 1'b0, 16'h0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // Reset during DATA bit 3 of the first byte
    @(posedge clk); #1;
    i_data  = 16'hA53C;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int i = 1; i <= 4 * B + 3; i++) begin
      @(posedge clk); #1;
    end
    check_eq("pre_rst_busy", 32'(o_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("async_rst_txd", 32'(uart_txd), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("post_rst_ready", 32'(o_ready), 32'd1);
    check_eq("post_rst_done", 32'(o_done), 32'd0);
    $display("mid-frame reset applied");
    send_word(16'h00FF, 1'b0, 16'h0, 1'b0, 1'b0);

    // Default divider
    @(posedge clk); #1;
    d_data  = 16'hA5A5;
    d_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    d_valid = 1'b0;
    first_low = -1;
    first_high = -1;
    done_at = -1;
    for (int i = 0; i < 17500 && done_at < 0; i++) begin
      @(posedge clk); #1;
      if (d_txd === 1'b0 && first_low < 0) first_low = cyc;
      if (d_txd === 1'b1 && first_low >= 0 && first_high < 0) first_high = cyc;
      if (d_done === 1'b1) done_at = cyc;
    end
    check_eq("def_start_edge", 32'(first_low - acc), 32'd1);
    check_eq("def_start_width", 32'(first_high - first_low), 32'd868);
    check_eq("def_word_cycles", 32'(done_at - first_low), 32'd17360);
    $display("default divider: start width %0d, word %0d cycles", first_high - first_low, done_at - first_low);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
